ext_code_seq_ctrl: RTL and testbench

- Synchronous sequencer that owns a DEPTH-entry code buffer for the 32-channel output port.
- Host loads codes through a valid/ready write port, then arms the block.
- Each external trigger pulse presents the next stored code on the channel outputs for the duration of the pulse.
- Sits between the host register interface and the channel drivers. Replaces flag/trigger-clocked buffering with a single-clock design.

---
 rtl/ext_code_seq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ext_code_seq_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ext_code_seq_ctrl.sv
// Trigger-driven code sequencer: the host fills a small code buffer, arms the block,
// and each external trigger pulse drives the next stored code onto the channel outputs.
module ext_code_seq_ctrl #(
  parameter int CH_WIDTH = 32,
  parameter int DEPTH    = 8,
  parameter int PTR_W    = 3
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iWr_valid,
  output logic                oWr_ready,
  input  logic [CH_WIDTH-1:0] iWr_data,
  input  logic                iClear,
  input  logic                iArm,
  input  logic                iAbort,
  input  logic                iLoop,
  input  logic                iTrigger,
  output logic [CH_WIDTH-1:0] oCode,
  output logic                oCode_valid,
  output logic [PTR_W:0]      oCount,
  output logic [1:0]          oState,
  output logic                oErr
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [CH_WIDTH-1:0] mem [DEPTH];

  logic [1:0]          state_q,  state_d;
  logic [CH_WIDTH-1:0] code_q,   code_d;
  logic                vld_q,    vld_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic                err_q,    err_d;

  logic trig_s1_q, trig_s2_q, trig_prev_q;
  logic trig_rise, trig_fall;
  logic wr_ready, wr_fire, rd_last;

  // Two-flop synchronizer followed by a registered edge detector
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      trig_s1_q   <= 1'b0;
      trig_s2_q   <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      trig_s1_q   <= iTrigger;
      trig_s2_q   <= trig_s1_q;
      trig_prev_q <= trig_s2_q;
    end
  end

  assign trig_rise = trig_s2_q & ~trig_prev_q;
  assign trig_fall = ~trig_s2_q & trig_prev_q;

  assign wr_ready = (state_q == ST_IDLE) && (cnt_q < DEPTH_C);
  assign wr_fire  = iWr_valid && wr_ready && !iClear;
  assign rd_last  = ({1'b0, rd_ptr_q} == (cnt_q - CNT_W'(1)));

  always_ff @(posedge iClk) begin
    if (wr_fire) begin
      mem[wr_ptr_q] <= iWr_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    vld_d    = vld_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = err_q;

    // Buffer maintenance is only possible while IDLE, even in an abort cycle
    if (state_q == ST_IDLE) begin
      if (iClear) begin
        cnt_d    = '0;
        wr_ptr_d = '0;
      end else if (wr_fire) begin
        cnt_d    = cnt_q + CNT_W'(1);
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
    end

    if (iAbort) begin
      state_d  = ST_IDLE;
      code_d   = '0;
      vld_d    = 1'b0;
      rd_ptr_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iArm) begin
            if (cnt_q != '0) begin
              state_d  = ST_ARMED;
              rd_ptr_d = '0;
              err_d    = 1'b0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_ARMED: begin
          if (iArm) begin
            rd_ptr_d = '0;
            code_d   = '0;
            vld_d    = 1'b0;
          end else if (trig_rise) begin
            code_d  = mem[rd_ptr_q];
            vld_d   = 1'b1;
            state_d = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (iArm) begin
            state_d  = ST_ARMED;
            rd_ptr_d = '0;
            code_d   = '0;
            vld_d    = 1'b0;
          end else if (trig_fall) begin
            code_d = '0;
            vld_d  = 1'b0;
            if (rd_last) begin
              if (iLoop) begin
                rd_ptr_d = '0;
                state_d  = ST_ARMED;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              rd_ptr_d = rd_ptr_q + PTR_W'(1);
              state_d  = ST_ARMED;
            end
          end
        end
        default: begin
          if (iArm) begin
            state_d  = ST_ARMED;
            rd_ptr_d = '0;
            err_d    = 1'b0;
          end else if (trig_rise) begin
            err_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= ST_IDLE;
      code_q   <= '0;
      vld_q    <= 1'b0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      vld_q    <= vld_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  assign oWr_ready   = wr_ready;
  assign oCode       = code_q;
  assign oCode_valid = vld_q;
  assign oCount      = cnt_q;
  assign oState      = state_q;
  assign oErr        = err_q;

endmodule

// File: tb/tb_ext_code_seq_ctrl.sv
// Directed bench for ext_code_seq_ctrl: buffer fill, trigger-driven replay, looping,
// error, abort and asynchronous reset cases.
module tb_ext_code_seq_ctrl;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iWr_valid = 1'b0;
  logic        oWr_ready;
  logic [31:0] iWr_data = '0;
  logic        iClear = 1'b0;
  logic        iArm = 1'b0;
  logic        iAbort = 1'b0;
  logic        iLoop = 1'b0;
  logic        iTrigger = 1'b0;
  logic [31:0] oCode;
  logic        oCode_valid;
  logic [3:0]  oCount;
  logic [1:0]  oState;
  logic        oErr;

  int total = 0;
  int bad   = 0;

  ext_code_seq_ctrl #(.CH_WIDTH(32), .DEPTH(8), .PTR_W(3)) dut (
    .iClk(iClk), .iRst(iRst), .iWr_valid(iWr_valid), .oWr_ready(oWr_ready),
    .iWr_data(iWr_data), .iClear(iClear), .iArm(iArm), .iAbort(iAbort),
    .iLoop(iLoop), .iTrigger(iTrigger), .oCode(oCode), .oCode_valid(oCode_valid),
    .oCount(oCount), .oState(oState), .oErr(oErr)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] d);
    @(posedge iClk); #1 iWr_valid = 1'b1; iWr_data = d;
    @(posedge iClk); #1 iWr_valid = 1'b0;
  endtask

  task automatic arm();
    @(posedge iClk); #1 iArm = 1'b1;
    @(posedge iClk); #1 iArm = 1'b0;
  endtask

  task automatic abort();
    @(posedge iClk); #1 iAbort = 1'b1;
    @(posedge iClk); #1 iAbort = 1'b0;
  endtask

  task automatic clear();
    @(posedge iClk); #1 iClear = 1'b1;
    @(posedge iClk); #1 iClear = 1'b0;
  endtask

  // 5-clock trigger pulse; output must follow each trigger edge by exactly 3 clocks
  task automatic trig_pulse(input string tag, input logic [31:0] exp_code, input logic exp_vld);
    @(posedge iClk); #1 iTrigger = 1'b1;
    repeat (2) @(posedge iClk);
    #1 chk({tag, "_pre"}, oCode, 32'h0);
    @(posedge iClk);
    #1 chk({tag, "_on"}, oCode, exp_code);
    chk({tag, "_vld"}, 32'(oCode_valid), 32'(exp_vld));
    repeat (2) @(posedge iClk);
    #1 iTrigger = 1'b0;
    repeat (2) @(posedge iClk);
    #1 chk({tag, "_hold"}, oCode, exp_code);
    @(posedge iClk);
    #1 chk({tag, "_off"}, oCode, 32'h0);
    chk({tag, "_offvld"}, 32'(oCode_valid), 32'h0);
    repeat (2) @(posedge iClk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge iClk);
    #1 iRst = 1'b0;
    chk("rst_state", 32'(oState), 32'd0);
    chk("rst_code", oCode, 32'h0);
    chk("rst_vld", 32'(oCode_valid), 32'h0);
    chk("rst_cnt", 32'(oCount), 32'd0);
    chk("rst_err", 32'(oErr), 32'd0);
    chk("rst_rdy", 32'(oWr_ready), 32'd1);

    // Basic three-code sequence
    wr(32'h11111111); wr(32'h22222222); wr(32'h33333333);
    chk("cnt3", 32'(oCount), 32'd3);
    arm();
    chk("armed", 32'(oState), 32'd1);
    trig_pulse("seq0", 32'h11111111, 1'b1);
    trig_pulse("seq1", 32'h22222222, 1'b1);
    trig_pulse("seq2", 32'h33333333, 1'b1);
    chk("done_state", 32'(oState), 32'd3);
    chk("done_cnt", 32'(oCount), 32'd3);

    // Extra trigger after DONE flags an error; re-arm clears it
    trig_pulse("done_trig", 32'h0, 1'b0);
    chk("done_err", 32'(oErr), 32'd1);
    chk("done_stay", 32'(oState), 32'd3);
    arm();
    chk("rearm_err", 32'(oErr), 32'd0);
    chk("rearm_state", 32'(oState), 32'd1);

    // Abort while the second code is showing
    trig_pulse("ab0", 32'h11111111, 1'b1);
    @(posedge iClk); #1 iTrigger = 1'b1;
    repeat (3) @(posedge iClk);
    #1 chk("ab_show", oCode, 32'h22222222);
    iAbort = 1'b1;
    @(posedge iClk); #1 iAbort = 1'b0;
    chk("ab_code", oCode, 32'h0);
    chk("ab_state", 32'(oState), 32'd0);
    chk("ab_cnt", 32'(oCount), 32'd3);
    iTrigger = 1'b0;
    repeat (4) @(posedge iClk);
    #1 arm();
    trig_pulse("ab_rearm", 32'h11111111, 1'b1);
    abort();

    // Arm with an empty buffer
    clear();
    chk("clr_cnt", 32'(oCount), 32'd0);
    arm();
    chk("empty_err", 32'(oErr), 32'd1);
    chk("empty_state", 32'(oState), 32'd0);

    // Fill to capacity and attempt one more write
    for (int i = 0; i < 8; i++) wr(32'h80000000 | 32'(i));
    chk("full_cnt", 32'(oCount), 32'd8);
    chk("full_rdy", 32'(oWr_ready), 32'd0);
    wr(32'hDEADBEEF);
    chk("full_cnt2", 32'(oCount), 32'd8);
    arm();
    for (int i = 0; i < 8; i++) trig_pulse($sformatf("full%0d", i), 32'h80000000 | 32'(i), 1'b1);
    chk("full_done", 32'(oState), 32'd3);
    abort();
    clear();

    // Looping over two codes
    wr(32'h0000000A); wr(32'h0000000B);
    iLoop = 1'b1;
    arm();
    trig_pulse("loop0", 32'h0000000A, 1'b1);
    trig_pulse("loop1", 32'h0000000B, 1'b1);
    trig_pulse("loop2", 32'h0000000A, 1'b1);
    trig_pulse("loop3", 32'h0000000B, 1'b1);
    trig_pulse("loop4", 32'h0000000A, 1'b1);
    chk("loop_state", 32'(oState), 32'd1);
    chk("loop_err", 32'(oErr), 32'd0);
    iLoop = 1'b0;

    // Asynchronous reset in the middle of a pulse
    arm();
    @(posedge iClk); #1 iTrigger = 1'b1;
    repeat (3) @(posedge iClk);
    #1 chk("rp_show", oCode, 32'h0000000A);
    #1 iRst = 1'b1;
    #1 chk("rp_code", oCode, 32'h0);
    chk("rp_vld", 32'(oCode_valid), 32'h0);
    @(posedge iClk); #1 iRst = 1'b0;
    chk("rp_state", 32'(oState), 32'd0);
    chk("rp_cnt", 32'(oCount), 32'd0);
    iTrigger = 1'b0;
    repeat (4) @(posedge iClk);
    trig_pulse("rp_ign", 32'h0, 1'b0);
    chk("rp_state2", 32'(oState), 32'd0);
    chk("rp_err", 32'(oErr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
